// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the multi-cycle add/sub datapath.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the saturation helper can describe.
  localparam int SAT_MAX_W = 64;

  // Most-negative (neg=1) or most-positive (neg=0) value of a width-bit signed word.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] msb;
    msb = '0;
    msb[width-1] = 1'b1;
    return neg ? msb : (msb - SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// chunk_adder: CHUNK-bit combinational ripple adder built from full-adder cells.
// Also exposes the carry into its MSB so the top can detect signed overflow.
module seq_addsub_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with a
// registered inter-chunk carry, valid/ready on both sides, optional saturation.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || WIDTH > SAT_MAX_W) begin : g_bad_params
      $error("seq_addsub: WIDTH must be >= 2 and an exact multiple of CHUNK >= 1");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               sat_q, sat_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_s;
  logic               chunk_co, chunk_c_msb;
  logic               last_chunk;
  logic               raw_ovf;
  logic [WIDTH-1:0]   sat_word;

  // Operand chunk selected by the running index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  seq_addsub_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (chunk_a),
    .b     (chunk_b),
    .ci    (carry_q),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  assign last_chunk = (idx_q == IDX_W'(N - 1));
  assign raw_ovf    = chunk_c_msb ^ chunk_co;
  // Saturation direction follows the sign of x, which a_q still holds unmodified.
  assign sat_word   = WIDTH'(sat_value(WIDTH, a_q[WIDTH-1]));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    sat_d       = sat_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = x;
          b_d     = (sel == OP_ADD) ? y : ~y;
          sat_d   = sat_en;
          carry_d = (sel == OP_SUB);
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            res_d[i*CHUNK +: CHUNK] = chunk_s;
          end
        end
        carry_d = chunk_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          ovf_d       = raw_ovf;
          cout_d      = chunk_co;
          sum_d       = (raw_ovf && sat_q) ? sat_word : res_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      sat_q       <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      sat_q       <= sat_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle two's-complement adder/subtractor. It processes CHUNK bits per clock through a narrow ripple chunk adder and carries the inter-chunk carry in a register. It is the area-scalable successor to the team's fixed 6-bit combinational add/sub: it adds arbitrary width, valid/ready handshakes on both sides and optional saturating arithmetic. It sits between an operand producer and a result consumer in datapath blocks that trade latency for adder area.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- CHUNK, 4: bits processed per cycle; must be ≥ 1 and divide WIDTH exactly, else elaboration error. N = WIDTH/CHUNK.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block is in IDLE and will accept operands.
- x  in  WIDTH  operand A, two's complement.
- y  in  WIDTH  operand B, two's complement.
- sel  in  1  0 = x+y, 1 = x−y.
- sat_en  in  1  1 = saturate on overflow.
- out_valid  out  1  result registers hold a new result.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- overflow  out  1  signed overflow of the raw operation; set even when saturated.
- carry_out  out  1  raw carry out of the MSB. For subtract, 1 means no borrow.

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state == IDLE).
- IDLE: when in_valid && in_ready, capture:
  - x and y^{WIDTH{sel}}
  - sat_en
  - carry register ← sel
  - chunk index ← 0
  - go to RUN
- RUN: each cycle, add chunk[idx] of both operands plus the carry register. Write the chunk result into the internal result register, update the carry register and increment idx.
  - On the last chunk (idx = N−1), capture the carry into the MSB (c_msb_in) and the carry out (c_msb_out).
  - Then load the outputs and go to DONE.
- Output load on leaving RUN:
  - overflow = c_msb_in ^ c_msb_out
  - carry_out = c_msb_out
  - If overflow && sat_en: sum = x[WIDTH−1] ? most-negative : most-positive. Otherwise sum = raw result.
  - out_valid ← 1.
- DONE: hold all outputs stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE.
- sum, overflow and carry_out change only on the RUN→DONE transition. They retain their value after the handshake until the next completion.
- in_valid is ignored outside IDLE. Operand inputs are not sampled after acceptance.
- Async reset (rst_n low): state = IDLE, and out_valid, sum, overflow, carry_out and all internal registers = 0. in_ready reads 1 during and after reset. Reset mid-RUN or in DONE discards the operation with no partial output.

## Timing
- Accept at edge E. Chunks are processed on edges E+1 … E+N. out_valid is high after edge E+N, so latency is N cycles.
- With out_ready held high, the handshake occurs at edge E+N+1. in_ready is high after E+N+1, and the next accept is at E+N+2. Peak throughput is one operation per N+2 cycles.
- CHUNK = WIDTH gives N = 1: a single RUN cycle.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package seq_addsub_pkg:
  - state enum {IDLE, RUN, DONE}
  - op constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - a function returning the saturation value for a given WIDTH and sign
- One sub-module: chunk_adder, a CHUNK-bit combinational ripple adder built from the team's FullAdder cells. Outputs: sum, carry out, and carry into its MSB.
- Top level: FSM, chunk index counter (width $clog2(N), minimum 1), operand/result/carry registers, saturation mux.

## Test plan
Use WIDTH=6, CHUNK=2 (N=3) unless noted.

1. x=5, y=3, sel=0 → sum=8 (0x08), overflow=0, carry_out=0. out_valid rises exactly 3 cycles after the accept edge.
2. x=31, y=1, sel=0:
   - sat_en=0 → sum=0x20 (−32), overflow=1, carry_out=0.
   - sat_en=1 → sum=0x1F, overflow=1.
3. x=0x20 (−32), y=1, sel=1:
   - sat_en=0 → sum=0x1F, overflow=1, carry_out=1.
   - sat_en=1 → sum=0x20.
4. x=7, y=7, sel=1 → sum=0, overflow=0, carry_out=1. Then hold out_ready=0 for 5 cycles while in_valid=1 with new operands: out_valid and sum stay stable, in_ready=0, and the new operands are not accepted until after the handshake.
5. Assert rst_n low during the 2nd RUN cycle → out_valid=0, sum=0, in_ready=1 immediately (asynchronously). The next operation (−3 + −4) → sum=0x39, overflow=0, carry_out=1.
6. WIDTH=16, CHUNK=16: x=0x7FFF, y=1, sel=0, sat_en=1 → sum=0x7FFF, overflow=1, out_valid one cycle after accept. Then 1000 random operand/mode pairs are checked against a reference model at WIDTH=16, CHUNK=4.
